power_mode_scheduler: RTL and testbench

Arbitrates power-mode requests from training, dueling and bulkhead requesters and sequences the one-hot power setting fed into the power-setting register stage. Enforces fixed priority, break-before-make transitions through an all-off settle window, and a minimum hold time per mode. Bulkhead requests preempt the hold time.

---
 rtl/power_mode_scheduler_pkg.sv | 28 ++
 rtl/power_mode_scheduler_if.sv | 27 ++
 rtl/power_req_prio.sv | 22 ++
 rtl/power_mode_scheduler.sv | 121 ++++++++++++
 tb/tb_power_mode_scheduler.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/power_mode_scheduler_pkg.sv
// Power mode scheduler shared definitions.
// Mode and state encodings, request bit indices, counter sizing.
package power_mode_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [2:0] PWR_OFF   = 3'b000;
    localparam logic [2:0] PWR_TRAIN = 3'b001;
    localparam logic [2:0] PWR_DUEL  = 3'b010;
    localparam logic [2:0] PWR_BULK  = 3'b100;

    localparam int REQ_TRAIN = 0;
    localparam int REQ_DUEL  = 1;
    localparam int REQ_BULK  = 2;

    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_MIN_HOLD      = 8;

    // Counter width for a down-counter loaded with n-1, never below 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/power_mode_scheduler_if.sv
// Request / power-setting bundle of the power mode scheduler.
// master drives req, slave returns the registered power setting.
interface power_mode_scheduler_if;

    logic [2:0] req;
    logic [2:0] pow_sel;
    logic       pow_valid;
    logic       busy;
    logic [7:0] switch_count;

    modport master (
        output req,
        input  pow_sel,
        input  pow_valid,
        input  busy,
        input  switch_count
    );

    modport slave (
        input  req,
        output pow_sel,
        output pow_valid,
        output busy,
        output switch_count
    );

endinterface

// File: rtl/power_req_prio.sv
// Fixed-priority request encoder: bulkhead > dueling > training.
// Produces a one-hot winner, or PWR_OFF when nothing is requested.
module power_req_prio
    import power_mode_scheduler_pkg::*;
(
    input  logic [2:0] req,
    output logic [2:0] win
);

    // Highest-priority requester wins outright.
    always_comb begin
        win = PWR_OFF;
        if (req[REQ_BULK]) begin
            win = PWR_BULK;
        end else if (req[REQ_DUEL]) begin
            win = PWR_DUEL;
        end else if (req[REQ_TRAIN]) begin
            win = PWR_TRAIN;
        end
    end

endmodule

// File: rtl/power_mode_scheduler.sv
// Power mode scheduler: break-before-make sequencing of one-hot
// power modes with settle window, minimum hold and bulkhead preemption.
module power_mode_scheduler
    import power_mode_scheduler_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int MIN_HOLD      = DEF_MIN_HOLD
) (
    input  logic                  clk,
    input  logic                  rst,
    power_mode_scheduler_if.slave bus
);

    localparam int SW = cnt_w(SETTLE_CYCLES);
    localparam int HW = cnt_w(MIN_HOLD);

    localparam logic [SW-1:0] SET_LOAD  = SW'(SETTLE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_HOLD - 1);

    state_t        state, state_n;
    logic [2:0]    target, target_n;
    logic [SW-1:0] settle_cnt, settle_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [2:0]    sel_q, sel_n;
    logic          valid_q;
    logic          busy_q;
    logic [7:0]    count_q, count_n;
    logic [2:0]    win;

    power_req_prio u_prio (
        .req (bus.req),
        .win (win)
    );

    // State and output registers; reset clears pow_sel immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            target     <= PWR_OFF;
            settle_cnt <= '0;
            hold_cnt   <= '0;
            sel_q      <= PWR_OFF;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state      <= state_n;
            target     <= target_n;
            settle_cnt <= settle_n;
            hold_cnt   <= hold_n;
            sel_q      <= sel_n;
            valid_q    <= (sel_n != PWR_OFF);
            busy_q     <= (state_n == ST_SETTLE);
            count_q    <= count_n;
        end
    end

    // Next-state logic: arbitration, settle countdown, hold countdown.
    always_comb begin
        state_n  = state;
        target_n = target;
        settle_n = settle_cnt;
        hold_n   = hold_cnt;
        sel_n    = sel_q;
        count_n  = count_q;
        case (state)
            ST_IDLE: begin
                sel_n = PWR_OFF;
                if (win != PWR_OFF) begin
                    state_n  = ST_SETTLE;
                    target_n = win;
                    settle_n = SET_LOAD;
                end
            end
            ST_SETTLE: begin
                sel_n = PWR_OFF;
                if (win == PWR_OFF) begin
                    state_n = ST_IDLE;
                end else begin
                    // A new winner retargets without restarting the window.
                    target_n = win;
                    if (settle_cnt == '0) begin
                        state_n = ST_ACTIVE;
                        sel_n   = win;
                        hold_n  = HOLD_LOAD;
                        count_n = count_q + 8'd1;
                    end else begin
                        settle_n = settle_cnt - SW'(1);
                    end
                end
            end
            ST_ACTIVE: begin
                if (hold_cnt != '0) begin
                    hold_n = hold_cnt - HW'(1);
                end
                if (win != sel_q) begin
                    if (win == PWR_BULK || hold_cnt == '0) begin
                        sel_n = PWR_OFF;
                        if (win != PWR_OFF) begin
                            state_n  = ST_SETTLE;
                            target_n = win;
                            settle_n = SET_LOAD;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
                sel_n   = PWR_OFF;
            end
        endcase
    end

    assign bus.pow_sel      = sel_q;
    assign bus.pow_valid    = valid_q;
    assign bus.busy         = busy_q;
    assign bus.switch_count = count_q;

endmodule

// File: tb/tb_power_mode_scheduler.sv
// Testbench for power_mode_scheduler: directed vector table, corner
// sequences and randomized traffic against a behavioural model.
module tb_power_mode_scheduler;
    import power_mode_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    power_mode_scheduler_if bus0 ();
    power_mode_scheduler_if bus1 ();

    assign bus1.req = bus0.req;

    power_mode_scheduler #(
        .SETTLE_CYCLES (4),
        .MIN_HOLD      (8)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    power_mode_scheduler #(
        .SETTLE_CYCLES (1),
        .MIN_HOLD      (1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] req;
        logic [2:0] sel;
        logic       busy;
        logic [7:0] cnt;
    } vec_t;

    vec_t vq[$];

    typedef struct {
        int on;
        int settling;
        int left;
        int tgt;
        int age;
        int cnt;
    } mdl_t;

    function automatic void add(input logic [2:0] r, input logic [2:0] s,
                                input logic b, input int c, input int n);
        vec_t v;
        v.req  = r;
        v.sel  = s;
        v.busy = b;
        v.cnt  = 8'(c);
        for (int i = 0; i < n; i++) vq.push_back(v);
    endfunction

    function automatic int winner(input logic [2:0] r);
        if (r[2]) return 4;
        if (r[1]) return 2;
        if (r[0]) return 1;
        return 0;
    endfunction

    // One clock edge of the scheduler's behaviour, in terms of
    // "how long has power been off / how long has this mode been on".
    function automatic mdl_t mstep(input mdl_t s, input logic [2:0] r,
                                   input int sc, input int mh);
        mdl_t n;
        int w;
        n = s;
        w = winner(r);
        if (s.on != 0) begin
            n.age = s.age + 1;
            if (w != s.on && (w == 4 || n.age >= mh)) begin
                n.on = 0;
                if (w != 0) begin
                    n.settling = 1;
                    n.left = sc;
                    n.tgt = w;
                end
            end
        end else if (s.settling != 0) begin
            if (w == 0) begin
                n.settling = 0;
            end else begin
                n.tgt = w;
                n.left = s.left - 1;
                if (n.left == 0) begin
                    n.on = w;
                    n.age = 0;
                    n.cnt = (s.cnt + 1) % 256;
                    n.settling = 0;
                end
            end
        end else if (w != 0) begin
            n.settling = 1;
            n.left = sc;
            n.tgt = w;
        end
        return n;
    endfunction

    task automatic chk(input string nm,
                       input logic [2:0] as, input logic av,
                       input logic ab, input logic [7:0] ac,
                       input logic [2:0] es, input logic eb,
                       input logic [7:0] ec);
        total++;
        if (as !== es || av !== (es != 3'b000) || ab !== eb || ac !== ec) begin
            bad++;
            $display("FAIL %s: got sel=%b valid=%b busy=%b cnt=%0d, want sel=%b valid=%b busy=%b cnt=%0d",
                     nm, as, av, ab, ac, es, (es != 3'b000), eb, ec);
        end
    endtask

    task automatic chk0(input string nm, input logic [2:0] es,
                        input logic eb, input logic [7:0] ec);
        chk(nm, bus0.pow_sel, bus0.pow_valid, bus0.busy,
            bus0.switch_count, es, eb, ec);
    endtask

    task automatic chk1(input string nm, input logic [2:0] es,
                        input logic eb, input logic [7:0] ec);
        chk(nm, bus1.pow_sel, bus1.pow_valid, bus1.busy,
            bus1.switch_count, es, eb, ec);
    endtask

    task automatic tick(input logic [2:0] r);
        @(negedge clk);
        bus0.req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus0.req = 3'b000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        mdl_t m0;
        mdl_t m1;
        logic [2:0] r;

        bus0.req = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        chk0("reset", 3'b000, 1'b0, 8'd0);
        chk1("reset_sc1", 3'b000, 1'b0, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // req, pow_sel, busy, switch_count after each edge, repeat count
        add(3'b001, 3'b000, 1'b1, 0, 4);
        add(3'b001, 3'b001, 1'b0, 1, 2);
        add(3'b010, 3'b001, 1'b0, 1, 6);
        add(3'b010, 3'b000, 1'b1, 1, 4);
        add(3'b010, 3'b010, 1'b0, 2, 1);
        add(3'b100, 3'b000, 1'b1, 2, 4);
        add(3'b100, 3'b100, 1'b0, 3, 1);
        add(3'b000, 3'b100, 1'b0, 3, 7);
        add(3'b000, 3'b000, 1'b0, 3, 1);
        add(3'b011, 3'b000, 1'b1, 3, 2);
        add(3'b000, 3'b000, 1'b0, 3, 2);
        add(3'b011, 3'b000, 1'b1, 3, 4);
        add(3'b011, 3'b010, 1'b0, 4, 2);
        add(3'b100, 3'b000, 1'b1, 4, 4);
        add(3'b100, 3'b100, 1'b0, 5, 1);

        foreach (vq[i]) begin
            tick(vq[i].req);
            chk0($sformatf("vec%0d", i), vq[i].sel, vq[i].busy, vq[i].cnt);
        end

        // Asynchronous reset while bulkhead is active.
        #2;
        rst = 1'b1;
        #1;
        chk0("async_rst", 3'b000, 1'b0, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        bus0.req = 3'b001;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk);
            #1;
            if (i < 5) chk0($sformatf("resume_settle%0d", i), 3'b000, 1'b1, 8'd0);
            else chk0("resume_active", 3'b001, 1'b0, 8'd1);
        end

        // Single-cycle settle and hold.
        do_reset();
        tick(3'b001);
        chk1("sc1_settle", 3'b000, 1'b1, 8'd0);
        chk0("sc4_settle", 3'b000, 1'b1, 8'd0);
        tick(3'b001);
        chk1("sc1_active", 3'b001, 1'b0, 8'd1);
        tick(3'b010);
        chk1("sc1_exit", 3'b000, 1'b1, 8'd1);
        tick(3'b010);
        chk1("sc1_duel", 3'b010, 1'b0, 8'd2);

        // switch_count wraps after 256 activations.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            repeat (5) tick(3'b001);
            repeat (8) tick(3'b000);
            if (i == 254) chk0("wrap255", 3'b000, 1'b0, 8'd255);
            if (i == 255) chk0("wrap0", 3'b000, 1'b0, 8'd0);
        end

        // Randomized traffic against the behavioural model.
        do_reset();
        m0 = '{default: 0};
        m1 = '{default: 0};
        r = 3'b000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 4) == 0) r = 3'($urandom_range(0, 7));
            tick(r);
            m0 = mstep(m0, r, 4, 8);
            m1 = mstep(m1, r, 1, 1);
            chk0($sformatf("rand0_%0d", i), 3'(m0.on), (m0.settling != 0),
                 8'(m0.cnt));
            chk1($sformatf("rand1_%0d", i), 3'(m1.on), (m1.settling != 0),
                 8'(m1.cnt));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
